// File: rtl/spi_burst_ram.sv
// SPI-side RAM endpoint: decodes 2-bit-tagged command words into address loads,
// writes and reads, with burst post-increment pointers and an error strobe.
module spi_burst_ram #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned WORD_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 rd_loaded;

    opcode_t              opcode;
    logic [WORD_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] addr_payload;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [ADDR_SIZE-1:0] wr_ptr_inc;
    logic [ADDR_SIZE-1:0] rd_ptr_inc;
    logic                 do_write;

    assign opcode       = opcode_t'(din[WORD_SIZE+1:WORD_SIZE]);
    assign payload      = din[WORD_SIZE-1:0];
    assign addr_payload = din[ADDR_SIZE-1:0];

    // A full power-of-two memory has no out-of-range addresses at all.
    generate
        if (MEM_DEPTH == (2 ** ADDR_SIZE)) begin : g_full_range
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end else begin : g_partial_range
            assign wr_in_range = (wr_ptr <= LAST_ADDR);
            assign rd_in_range = (rd_ptr <= LAST_ADDR);
        end
    endgenerate

    assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_SIZE'(1);
    assign rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_SIZE'(1);

    assign do_write = rx_valid && (opcode == OP_WR_DATA) && wr_in_range;

    // Storage is deliberately left out of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            tx_valid  <= 1'b0;
            err       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_loaded <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            if (rx_valid) begin
                case (opcode)
                    OP_WR_ADDR: wr_ptr <= addr_payload;
                    OP_WR_DATA: begin
                        if (wr_in_range) begin
                            if (AUTO_INC) begin
                                wr_ptr <= wr_ptr_inc;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_RD_ADDR: begin
                        rd_ptr    <= addr_payload;
                        rd_loaded <= 1'b1;
                    end
                    OP_RD_DATA: begin
                        if (rd_loaded && rd_in_range) begin
                            dout     <= mem[rd_ptr];
                            tx_valid <= 1'b1;
                            if (AUTO_INC) begin
                                rd_ptr <= rd_ptr_inc;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: err <= 1'b0;
                endcase
            end
        end
    end

endmodule
